// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults for the byte-wide synchronous FIFO
//
// Purpose: holds the default data width and depth, and the matching pointer
// width, so the top level and the storage array agree on their sizes.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 8;
  localparam int PTR_W          = $clog2(DEPTH_DEF);

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - simple dual-port register array for the FIFO storage
//
// Purpose: DEPTH x DATA_WIDTH storage. Writes happen on the rising edge and
// reads are a combinational index. The array has no reset: only pointers and
// count decide which entries are valid.
// Ports:
//   i_clk      clock
//   i_wr_en    write strobe
//   i_wr_addr  write index
//   i_wr_data  write data
//   i_rd_addr  read index
//   o_rd_data  data at i_rd_addr (combinational)
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]         i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with push/pop strobes and level flags
//
// Purpose: small elastic buffer between a producer and a consumer on one
// clock. Overflowing pushes and underflowing pops are dropped silently.
// Ports:
//   clk           clock, all state on the rising edge
//   rst           asynchronous active-high reset
//   push          write request, data_in captured on the same edge
//   pop           read request, head entry moved to data_out on the same edge
//   data_in       write data
//   data_out      registered read data, held until the next accepted pop
//   empty         count == 0
//   almost_empty  count <= AE_LEVEL
//   full          count == DEPTH
//   almost_full   count >= DEPTH - AF_LEVEL
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int AE_LEVEL   = 1,
  parameter int AF_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  full,
  output logic                  almost_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] C_AE   = CW'(AE_LEVEL);
  localparam logic [CW-1:0] C_AF   = CW'(DEPTH - AF_LEVEL);

  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop_ok;
  logic                  w_push_ok;

  // Flags come from the count only; pointer equality is ambiguous at full/empty.
  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == C_FULL);
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_empty = (r_count <= C_AE);
  assign almost_full  = (r_count >= C_AF);
  assign data_out     = r_data_out;

  // A pop on a full FIFO frees a slot in the same edge, so the push may use it.
  assign w_pop_ok  = pop && !w_empty;
  assign w_push_ok = push && (!w_full || w_pop_ok);

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (PW)
  ) u_mem (
    .i_clk      (clk),
    .i_wr_en    (w_push_ok),
    .i_wr_addr  (r_wr_ptr),
    .i_wr_data  (data_in),
    .i_rd_addr  (r_rd_ptr),
    .o_rd_data  (w_rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr   <= r_rd_ptr + PW'(1);
        r_data_out <= w_rd_data;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - scoreboard bench for sync_fifo with directed vectors
module tb_sync_fifo;

  logic       clk;
  logic       rst;
  logic       push;
  logic       pop;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       empty;
  logic       almost_empty;
  logic       full;
  logic       almost_full;

  int n_cmp;
  int n_bad;

  logic [7:0] sb_q[$];

  sync_fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (8),
    .AE_LEVEL   (1),
    .AF_LEVEL   (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .pop          (pop),
    .data_in      (data_in),
    .data_out     (data_out),
    .empty        (empty),
    .almost_empty (almost_empty),
    .full         (full),
    .almost_full  (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_flags(input string tag, input logic e, input logic ae,
                           input logic f, input logic af);
    check({tag, ".empty"}, {31'd0, empty}, {31'd0, e});
    check({tag, ".almost_empty"}, {31'd0, almost_empty}, {31'd0, ae});
    check({tag, ".full"}, {31'd0, full}, {31'd0, f});
    check({tag, ".almost_full"}, {31'd0, almost_full}, {31'd0, af});
  endtask

  // One clock of stimulus. When a pop is issued the expected data_out after
  // that edge goes into the scoreboard queue for the monitor.
  task automatic step(input logic p, input logic q, input logic [7:0] d, input logic [7:0] exp);
    @(negedge clk);
    push    = p;
    pop     = q;
    data_in = d;
    if (q) sb_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  // Monitor: after every edge that saw a pop strobe, compare data_out with
  // the oldest expected value.
  always begin
    logic pop_at_edge;
    logic rst_at_edge;
    logic [7:0] exp;
    @(posedge clk);
    pop_at_edge = pop;
    rst_at_edge = rst;
    @(negedge clk);
    if (pop_at_edge && !rst_at_edge) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard: pop seen with no expected value, data_out=%0h", data_out);
      end else begin
        exp = sb_q.pop_front();
        check("pop.data_out", {24'd0, data_out}, {24'd0, exp});
      end
    end
  end

  initial begin
    logic [7:0] fill_v [8];
    logic [7:0] exp_ae;
    logic [7:0] exp_af;
    logic [7:0] exp_full;
    logic [7:0] drain_v [10];

    fill_v = '{8'hAA, 8'hFA, 8'hAF, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h04};
    drain_v = '{8'hAA, 8'hFA, 8'hAF, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h04, 8'h04, 8'h04};
    // bit i = flag value after push i+1
    exp_ae   = 8'b0000_0001;
    exp_af   = 8'b1100_0000;
    exp_full = 8'b1000_0000;

    n_cmp = 0;
    n_bad = 0;
    push = 1'b0;
    pop = 1'b0;
    data_in = 8'h00;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_flags("reset", 1'b1, 1'b1, 1'b0, 1'b0);
    check("reset.data_out", {24'd0, data_out}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Fill
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, fill_v[i], 8'h00);
      chk_flags($sformatf("fill%0d", i + 1), 1'b0, exp_ae[i], exp_full[i], exp_af[i]);
    end
    check("fill.no_fallthrough", {24'd0, data_out}, 32'h0);

    // Overflow: all pushes dropped
    step(1'b1, 1'b0, 8'h04, 8'h00);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 8'h08, 8'h00);
      check("overflow.full", {31'd0, full}, 32'd1);
    end
    step(1'b0, 1'b0, 8'h00, 8'h00);

    // Drain: ten pops separated by four idle cycles
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 8'h00, drain_v[i]);
      if (i == 6) check("drain7.empty", {31'd0, empty}, 32'd0);
      if (i == 7) chk_flags("drain8", 1'b1, 1'b1, 1'b0, 1'b0);
      repeat (4) step(1'b0, 1'b0, 8'h00, 8'h00);
    end
    chk_flags("drained", 1'b1, 1'b1, 1'b0, 1'b0);

    // Simultaneous push/pop while full
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h10 + 8'(i), 8'h00);
    step(1'b1, 1'b1, 8'h55, 8'h10);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    chk_flags("pp_full", 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i < 8; i++) step(1'b0, 1'b1, 8'h00, 8'h10 + 8'(i));
    step(1'b0, 1'b1, 8'h00, 8'h55);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    chk_flags("pp_drained", 1'b1, 1'b1, 1'b0, 1'b0);

    // Simultaneous push/pop while empty: push wins, data_out unchanged
    step(1'b1, 1'b1, 8'h66, 8'h55);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    chk_flags("pp_empty", 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 8'h66);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    check("pp_empty.after_pop", {31'd0, empty}, 32'd1);

    // Wrap: hold count at 3 for 12 push/pop pairs
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'hA0 + 8'(i), 8'h00);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'hB0 + 8'(i), 8'hA0 + 8'(i));
    for (int i = 3; i < 12; i++) step(1'b1, 1'b1, 8'hB0 + 8'(i), 8'hB0 + 8'(i - 3));
    step(1'b0, 1'b0, 8'h00, 8'h00);
    chk_flags("wrap", 1'b0, 1'b0, 1'b0, 1'b0);
    check("wrap.data_out", {24'd0, data_out}, 32'hB8);

    // Asynchronous reset mid-stream, checked before any clock edge
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_flags("async_rst", 1'b1, 1'b1, 1'b0, 1'b0);
    check("async_rst.data_out", {24'd0, data_out}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 8'hC3, 8'h00);
    step(1'b0, 1'b1, 8'h00, 8'hC3);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    check("post_rst.empty", {31'd0, empty}, 32'd1);

    repeat (2) @(posedge clk);
    check("scoreboard.leftover", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
